multi_edge_detector: RTL and testbench
======================================

# multi_edge_detector

Parametrised, multi-channel successor to the single-channel edge detector. Each of `CHANNELS` asynchronous inputs passes through a synchroniser and debounce filter. A per-channel mode selects rising, falling, both or no edges; qualifying edges raise a one-cycle strobe and a sticky pending flag. Sits between raw board inputs (buttons, switches, external strobes) and control logic that polls or reacts to events.

## Interface
Parameters:
- `CHANNELS`, 4: number of independent input channels, ≥1.
- `SYNC_STAGES`, 2: synchroniser flip-flops per channel, ≥2.
- `DEBOUNCE_CYCLES`, 4: consecutive cycles a new level must persist before acceptance, ≥1. Counter width is `$clog2(DEBOUNCE_CYCLES+1)`.

Ports:
- `in_clock`  in  1  sole clock; all state updates on the rising edge.
- `in_reset_n`  in  1  reset, asynchronous assert, active-low.
- `in_signal`  in  CHANNELS  raw asynchronous inputs.
- `in_mode`  in  2*CHANNELS  per-channel mode, bits [2i+1:2i]: 00 off, 01 rising, 10 falling, 11 both.
- `in_clear`  in  CHANNELS  write-one-clear of `out_pending[i]` and `out_overflow[i]`.
- `out_level`  out  CHANNELS  debounced level.
- `out_strobe`  out  CHANNELS  one-cycle pulse per qualifying edge.
- `out_pending`  out  CHANNELS  sticky event flag.
- `out_overflow`  out  CHANNELS  qualifying edge arrived while pending already set.
- `out_any`  out  1  OR of `out_pending`.

## Operation
- Synchroniser: shift chain of `SYNC_STAGES` flops per channel; the last stage is the synced sample.
- Debounce: per-channel counter `cnt`.
  - synced == `out_level`: `cnt` ← 0.
  - Otherwise `cnt` increments.
  - When the increment would reach `DEBOUNCE_CYCLES`: `out_level` ← synced and `cnt` ← 0 on that edge.
- Edge qualification on a level update: a 0→1 update is a rise, a 1→0 update is a fall. It qualifies when mode is 01 (rise), 10 (fall) or 11 (either). Mode 00 never qualifies, but the level still tracks.
- Qualifying edge: `out_strobe[i]` ← 1 for exactly one cycle, coincident with the `out_level` change.
- Pending/overflow update priority per channel, each cycle:
  - Qualifying edge and pending=1 and no clear: overflow ← 1.
  - Qualifying edge and clear: pending stays 1, overflow ← 0. Set wins for pending.
  - Qualifying edge otherwise: pending ← 1.
  - Clear with no edge: pending ← 0, overflow ← 0.
- Mode changes take effect on the next edge. A mode change alone never generates a strobe.
- Channels are fully independent; simultaneous edges on several channels all register.

## Timing
- Reset (asynchronous, `in_reset_n`=0): sync flops, `cnt`, `out_level`, `out_strobe`, `out_pending`, `out_overflow` all 0. `out_any` = 0.
- Reset mid-debounce discards the partial count. An input held high through reset deassertion produces a rise after full latency.
- Latency: `out_level`/`out_strobe` change on the (`SYNC_STAGES`+`DEBOUNCE_CYCLES`)-th rising edge after the input change is first sampled. Defaults give the 6th edge.
- Pending sets on the same edge as the strobe. `out_any` is combinational from the pending flags.
- A pulse or glitch shorter than `DEBOUNCE_CYCLES` cycles at the synced output causes no level change and no strobe.
- Minimum spacing between strobes on one channel: `DEBOUNCE_CYCLES` cycles.
- All outputs are registered except `out_any`.

## Structure
- Package `edge_detector_pkg`:
  - mode constants `MODE_OFF`=2'b00, `MODE_RISE`=2'b01, `MODE_FALL`=2'b10, `MODE_BOTH`=2'b11;
  - a mode typedef.
- Sub-module `edge_channel`: one channel containing synchroniser, debounce counter, edge qualification, pending/overflow. Carries the same `SYNC_STAGES`/`DEBOUNCE_CYCLES` parameters.
- Top level instantiates `edge_channel` `CHANNELS` times in a generate loop, slices `in_mode`, and forms `out_any`.

## Test plan
- Reset, then ch0 mode 01, `in_signal[0]` 0→1 held -> `out_level[0]` and `out_strobe[0]` high on 6th edge, strobe width 1 cycle, `out_pending[0]`=1, `out_any`=1.
- Ch1 mode 10, 3-cycle high glitch, then 0→1 held, then 1→0 -> glitch ignored. No strobe on the rise. Strobe on the fall 6 edges after the fall.
- Ch2 mode 11, two debounced edges without clear -> two strobes, pending=1, overflow=1. Pulse `in_clear[2]` -> both 0 next edge.
- Ch3 mode 01, `in_clear[3]` asserted on the same edge as a qualifying rise -> pending=1, overflow=0.
- Mode 00 on all channels, toggle all inputs -> `out_level` tracks, no strobes, pending stays 0. Assert `in_reset_n`=0 mid-debounce -> all outputs 0 immediately, no strobe after release until full latency.

Source files
------------

// File: rtl/edge_detector_pkg.sv
// Shared mode encoding and edge qualification for the multi-channel edge detector.
package edge_detector_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_OFF  = 2'b00;
    localparam mode_t MODE_RISE = 2'b01;
    localparam mode_t MODE_FALL = 2'b10;
    localparam mode_t MODE_BOTH = 2'b11;

    // rising = 1 for a 0->1 level update, 0 for a 1->0 update.
    function automatic logic edge_qualifies(input mode_t mode, input logic rising);
        logic q;
        q = 1'b0;
        if (rising) begin
            q = (mode == MODE_RISE) || (mode == MODE_BOTH);
        end else begin
            q = (mode == MODE_FALL) || (mode == MODE_BOTH);
        end
        return q;
    endfunction

endpackage

// File: rtl/edge_channel.sv
// One input channel: synchroniser, debounce filter, edge qualification and sticky
// pending/overflow flags.
module edge_channel
    import edge_detector_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       signal_i,
    input  logic [1:0] mode_i,
    input  logic       clear_i,
    output logic       level_o,
    output logic       strobe_o,
    output logic       pending_o,
    output logic       overflow_o
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CntW-1:0]        cnt_q, cnt_d, cnt_inc;
    logic                   level_q, level_d;
    logic                   strobe_q, strobe_d;
    logic                   pending_q, pending_d;
    logic                   overflow_q, overflow_d;
    logic                   synced;
    logic                   update;
    logic                   qualify;

    assign synced  = sync_q[SYNC_STAGES-1];
    assign cnt_inc = cnt_q + CntW'(1);

    always_comb begin
        sync_d     = {sync_q[SYNC_STAGES-2:0], signal_i};
        cnt_d      = '0;
        level_d    = level_q;
        update     = 1'b0;
        if (synced != level_q) begin
            if (cnt_inc == CntMax) begin
                update  = 1'b1;
                level_d = synced;
            end else begin
                cnt_d = cnt_inc;
            end
        end

        qualify    = update && edge_qualifies(mode_t'(mode_i), synced);
        strobe_d   = qualify;

        // A coincident clear loses to the edge for pending but still drops overflow.
        pending_d  = pending_q;
        overflow_d = overflow_q;
        if (qualify && clear_i) begin
            pending_d  = 1'b1;
            overflow_d = 1'b0;
        end else if (qualify && pending_q) begin
            overflow_d = 1'b1;
        end else if (qualify) begin
            pending_d = 1'b1;
        end else if (clear_i) begin
            pending_d  = 1'b0;
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q     <= '0;
            cnt_q      <= '0;
            level_q    <= 1'b0;
            strobe_q   <= 1'b0;
            pending_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            cnt_q      <= cnt_d;
            level_q    <= level_d;
            strobe_q   <= strobe_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
        end
    end

    assign level_o    = level_q;
    assign strobe_o   = strobe_q;
    assign pending_o  = pending_q;
    assign overflow_o = overflow_q;

endmodule

// File: rtl/multi_edge_detector.sv
// Multi-channel debounced edge detector: independent channels plus a combined
// any-pending flag.
module multi_edge_detector #(
    parameter int unsigned CHANNELS        = 4,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic                  in_clock,
    input  logic                  in_reset_n,
    input  logic [CHANNELS-1:0]   in_signal,
    input  logic [2*CHANNELS-1:0] in_mode,
    input  logic [CHANNELS-1:0]   in_clear,
    output logic [CHANNELS-1:0]   out_level,
    output logic [CHANNELS-1:0]   out_strobe,
    output logic [CHANNELS-1:0]   out_pending,
    output logic [CHANNELS-1:0]   out_overflow,
    output logic                  out_any
);

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        edge_channel #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_chan (
            .clk_i      (in_clock),
            .rst_ni     (in_reset_n),
            .signal_i   (in_signal[g]),
            .mode_i     (in_mode[2*g +: 2]),
            .clear_i    (in_clear[g]),
            .level_o    (out_level[g]),
            .strobe_o   (out_strobe[g]),
            .pending_o  (out_pending[g]),
            .overflow_o (out_overflow[g])
        );
    end

    assign out_any = |out_pending;

endmodule

// File: tb/tb_multi_edge_detector.sv
// Directed self-checking bench for multi_edge_detector with default parameters.
module tb_multi_edge_detector;

    logic       clk;
    logic       rst_n;
    logic [3:0] in_signal;
    logic [7:0] in_mode;
    logic [3:0] in_clear;
    logic [3:0] out_level;
    logic [3:0] out_strobe;
    logic [3:0] out_pending;
    logic [3:0] out_overflow;
    logic       out_any;

    logic [3:0] strobe_acc;
    int         n_checks;
    int         n_errors;

    multi_edge_detector #(
        .CHANNELS        (4),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .in_clock     (clk),
        .in_reset_n   (rst_n),
        .in_signal    (in_signal),
        .in_mode      (in_mode),
        .in_clear     (in_clear),
        .out_level    (out_level),
        .out_strobe   (out_strobe),
        .out_pending  (out_pending),
        .out_overflow (out_overflow),
        .out_any      (out_any)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, ending at a falling edge; collect any strobe seen.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            strobe_acc |= out_strobe;
        end
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        strobe_acc = '0;
        rst_n      = 1'b0;
        in_signal  = '0;
        in_mode    = '0;
        in_clear   = '0;

        // Reset state
        step(2);
        check_eq("rst_level", 32'(out_level), 32'h0);
        check_eq("rst_strobe", 32'(out_strobe), 32'h0);
        check_eq("rst_pending", 32'(out_pending), 32'h0);
        check_eq("rst_overflow", 32'(out_overflow), 32'h0);
        check_eq("rst_any", 32'(out_any), 32'h0);
        rst_n = 1'b1;
        step(1);

        // Ch0 rising: level and strobe on the 6th edge, one cycle wide
        in_mode[1:0] = 2'b01;
        in_signal[0] = 1'b1;
        step(5);
        check_eq("ch0_level_e5", 32'(out_level[0]), 32'h0);
        check_eq("ch0_strobe_e5", 32'(out_strobe[0]), 32'h0);
        step(1);
        check_eq("ch0_level_e6", 32'(out_level[0]), 32'h1);
        check_eq("ch0_strobe_e6", 32'(out_strobe), 32'h1);
        check_eq("ch0_pending", 32'(out_pending), 32'h1);
        check_eq("ch0_any", 32'(out_any), 32'h1);
        step(1);
        check_eq("ch0_strobe_e7", 32'(out_strobe[0]), 32'h0);
        check_eq("ch0_level_e7", 32'(out_level[0]), 32'h1);

        // Ch1 falling: short glitch ignored, rise unqualified, fall strobes
        in_mode[3:2] = 2'b10;
        strobe_acc   = '0;
        in_signal[1] = 1'b1;
        step(3);
        in_signal[1] = 1'b0;
        step(8);
        check_eq("ch1_glitch_level", 32'(out_level[1]), 32'h0);
        check_eq("ch1_glitch_strobe", 32'(strobe_acc[1]), 32'h0);
        in_signal[1] = 1'b1;
        step(6);
        check_eq("ch1_rise_level", 32'(out_level[1]), 32'h1);
        check_eq("ch1_rise_strobe", 32'(strobe_acc[1]), 32'h0);
        check_eq("ch1_rise_pending", 32'(out_pending[1]), 32'h0);
        in_signal[1] = 1'b0;
        step(5);
        check_eq("ch1_fall_level_e5", 32'(out_level[1]), 32'h1);
        step(1);
        check_eq("ch1_fall_level_e6", 32'(out_level[1]), 32'h0);
        check_eq("ch1_fall_strobe", 32'(out_strobe[1]), 32'h1);
        check_eq("ch1_fall_pending", 32'(out_pending[1]), 32'h1);

        // Ch2 both: two edges set overflow, edge+clear keeps pending, clear drops both
        in_mode[5:4] = 2'b11;
        in_signal[2] = 1'b1;
        step(6);
        check_eq("ch2_e1_strobe", 32'(out_strobe[2]), 32'h1);
        check_eq("ch2_e1_overflow", 32'(out_overflow[2]), 32'h0);
        in_signal[2] = 1'b0;
        step(6);
        check_eq("ch2_e2_strobe", 32'(out_strobe[2]), 32'h1);
        check_eq("ch2_e2_pending", 32'(out_pending[2]), 32'h1);
        check_eq("ch2_e2_overflow", 32'(out_overflow[2]), 32'h1);
        in_signal[2] = 1'b1;
        step(5);
        in_clear[2] = 1'b1;
        step(1);
        in_clear[2] = 1'b0;
        check_eq("ch2_e3clr_strobe", 32'(out_strobe[2]), 32'h1);
        check_eq("ch2_e3clr_pending", 32'(out_pending[2]), 32'h1);
        check_eq("ch2_e3clr_overflow", 32'(out_overflow[2]), 32'h0);
        step(2);
        in_clear[2] = 1'b1;
        step(1);
        in_clear[2] = 1'b0;
        check_eq("ch2_clr_pending", 32'(out_pending[2]), 32'h0);
        check_eq("ch2_clr_overflow", 32'(out_overflow[2]), 32'h0);

        // Ch3 rising with clear on the same edge as the qualifying rise
        in_mode[7:6] = 2'b01;
        in_signal[3] = 1'b1;
        step(5);
        in_clear[3] = 1'b1;
        step(1);
        in_clear[3] = 1'b0;
        check_eq("ch3_strobe", 32'(out_strobe[3]), 32'h1);
        check_eq("ch3_pending", 32'(out_pending[3]), 32'h1);
        check_eq("ch3_overflow", 32'(out_overflow[3]), 32'h0);

        // Clear everything, then mode off on all channels and toggle all inputs
        in_clear = 4'hF;
        step(1);
        in_clear = 4'h0;
        check_eq("clrall_pending", 32'(out_pending), 32'h0);
        check_eq("clrall_any", 32'(out_any), 32'h0);
        check_eq("pre_off_level", 32'(out_level), 32'hD);
        in_mode    = 8'h00;
        strobe_acc = '0;
        in_signal  = 4'b0010;
        step(6);
        check_eq("off_level", 32'(out_level), 32'h2);
        check_eq("off_strobes", 32'(strobe_acc), 32'h0);
        check_eq("off_pending", 32'(out_pending), 32'h0);

        // Reset mid-debounce: immediate clear, then full latency after release
        in_mode    = 8'h01;
        in_signal  = 4'b0011;
        step(4);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_level", 32'(out_level), 32'h0);
        check_eq("midrst_pending", 32'(out_pending), 32'h0);
        check_eq("midrst_strobe", 32'(out_strobe), 32'h0);
        step(2);
        rst_n      = 1'b1;
        strobe_acc = '0;
        step(5);
        check_eq("postrst_level_e5", 32'(out_level), 32'h0);
        check_eq("postrst_strobe_e5", 32'(strobe_acc), 32'h0);
        step(1);
        check_eq("postrst_level_e6", 32'(out_level), 32'h3);
        check_eq("postrst_strobe_e6", 32'(out_strobe), 32'h1);
        check_eq("postrst_any", 32'(out_any), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
